// File: rtl/resampler_pkg.sv
// Shared defaults and state encoding for the multi-stream resampling tap buffer.
package resampler_pkg;

    localparam int DEF_DWIDTH     = 16;
    localparam int DEF_TAPS       = 4;
    localparam int DEF_NR_STREAMS = 16;
    localparam int DEF_L          = 160;
    localparam int DEF_M          = 147;

    typedef enum logic [1:0] {
        ST_DECIDE = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EMIT   = 2'd2
    } tap_state_e;

    // A single stream still needs a one-bit id port.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/resample_phase_ctrl.sv
// L/M phase accumulator: each step decides whether the frame consumes a new input sample.
module resample_phase_ctrl #(
    parameter int L  = 160,
    parameter int M  = 147,
    localparam int AW = $clog2(2 * L)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    output logic          shift,
    output logic [AW-1:0] acc
);

    logic [AW-1:0] acc_r;
    logic [AW-1:0] sum_s;

    // Next-phase sum and shift decision for the current frame.
    always_comb begin
        sum_s = acc_r + AW'(M);
        shift = (sum_s >= AW'(L));
    end

    // Phase accumulator stays within 0..L-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= '0;
        end else if (step) begin
            acc_r <= shift ? (sum_s - AW'(L)) : sum_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/multistream_tap_buffer.sv
// Interleaved per-stream tap-history buffer; emits one TAPS-sample window per stream each frame.
module multistream_tap_buffer
    import resampler_pkg::*;
#(
    parameter int DWIDTH     = DEF_DWIDTH,
    parameter int TAPS       = DEF_TAPS,
    parameter int NR_STREAMS = DEF_NR_STREAMS,
    parameter int L          = DEF_L,
    parameter int M          = DEF_M,
    localparam int SW        = id_width(NR_STREAMS),
    localparam int WW        = TAPS * DWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    output logic              req_in,
    input  logic              ack_in,
    input  logic [DWIDTH-1:0] data_in,
    output logic              req_out,
    input  logic              ack_out,
    output logic [WW-1:0]     data_out,
    output logic [SW-1:0]     stream_id,
    output logic              shifted
);

    localparam int AW = $clog2(2 * L);

    tap_state_e     state_r;
    logic [SW-1:0]  s_r;
    logic [WW-1:0]  hist_r [NR_STREAMS];
    logic [WW-1:0]  new_win_s;
    logic           step_s;
    logic           shift_s;
    logic [AW-1:0]  acc_s;

    resample_phase_ctrl #(
        .L (L),
        .M (M)
    ) u_phase (
        .clk   (clk),
        .rst   (rst),
        .step  (step_s),
        .shift (shift_s),
        .acc   (acc_s)
    );

    // Accumulator advances once per frame, in DECIDE; window shifts newest sample into the MSBs.
    always_comb begin
        step_s    = (state_r == ST_DECIDE);
        new_win_s = {data_in, hist_r[s_r][WW-1:DWIDTH]};
    end

    // Frame sequencer: DECIDE -> (FETCH -> EMIT)* or EMIT* back to DECIDE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_DECIDE;
            s_r       <= '0;
            req_in    <= 1'b0;
            req_out   <= 1'b0;
            data_out  <= '0;
            stream_id <= '0;
            shifted   <= 1'b0;
            for (int i = 0; i < NR_STREAMS; i++) begin
                hist_r[i] <= '0;
            end
        end else begin
            case (state_r)
                ST_DECIDE: begin
                    s_r       <= '0;
                    shifted   <= shift_s;
                    stream_id <= '0;
                    if (shift_s) begin
                        req_in  <= 1'b1;
                        state_r <= ST_FETCH;
                    end else begin
                        req_out  <= 1'b1;
                        data_out <= hist_r[0];
                        state_r  <= ST_EMIT;
                    end
                end
                ST_FETCH: begin
                    if (ack_in) begin
                        hist_r[s_r] <= new_win_s;
                        data_out    <= new_win_s;
                        stream_id   <= s_r;
                        req_in      <= 1'b0;
                        req_out     <= 1'b1;
                        state_r     <= ST_EMIT;
                    end else begin
                        req_in <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (ack_out) begin
                        if (s_r == SW'(NR_STREAMS - 1)) begin
                            s_r     <= '0;
                            req_out <= 1'b0;
                            state_r <= ST_DECIDE;
                        end else begin
                            s_r <= s_r + SW'(1);
                            if (shifted) begin
                                req_out <= 1'b0;
                                req_in  <= 1'b1;
                                state_r <= ST_FETCH;
                            end else begin
                                data_out  <= hist_r[s_r + SW'(1)];
                                stream_id <= s_r + SW'(1);
                            end
                        end
                    end else begin
                        req_out <= 1'b1;
                    end
                end
                default: begin
                    req_in  <= 1'b0;
                    req_out <= 1'b0;
                    s_r     <= '0;
                    state_r <= ST_DECIDE;
                end
            endcase
        end
    end

endmodule

// File: doc/multistream_tap_buffer.md
MULTISTREAM_TAP_BUFFER -- requirements
Module: multistream_tap_buffer

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, sample width in bits.
REQ-002 SHALL have parameter TAPS, default 4, history depth per stream (legal: 2..16).
REQ-003 SHALL have parameter NR_STREAMS, default 16, interleaved channel count (legal: 1..256, power of two not required).
REQ-004 SHALL have parameters L, default 160, and M, default 147, resampling ratio L/M (legal: 1 <= M <= L).
REQ-005 SHALL have port clk  input  1  clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port req_in  output  1  block ready to accept data_in.
REQ-008 SHALL have port ack_in  input  1  source presents valid data_in.
REQ-009 SHALL have port data_in  input  DWIDTH  incoming sample for current stream.
REQ-010 SHALL have port req_out  output  1  data_out/stream_id valid.
REQ-011 SHALL have port ack_out  input  1  sink accepts output.
REQ-012 SHALL have port data_out  output  TAPS*DWIDTH  tap window; slice 0 (MSBs) newest, slice TAPS-1 oldest.
REQ-013 SHALL have port stream_id  output  clog2(NR_STREAMS)  stream of current data_out.
REQ-014 SHALL have port shifted  output  1  current frame consumed new input.

Function
REQ-015 SHALL hold history hist[s][0..TAPS-1] per stream; shift: hist[s] <= {data_in, hist[s][0..TAPS-2]}.
REQ-016 SHALL transfer input only on cycles with req_in && ack_in; output only on req_out && ack_out.
REQ-017 SHALL never assert req_in and req_out in the same cycle.
REQ-018 SHALL implement states DECIDE, FETCH, EMIT; DECIDE entered after reset.
REQ-019 DECIDE (1 cycle): shift = (acc+M >= L); acc <= shift ? acc+M-L : acc+M; s <= 0; shifted <= shift; next FETCH if shift else EMIT with data_out <= hist[0].
REQ-020 FETCH: req_in=1; on transfer apply REQ-015 to hist[s], data_out <= new window, next EMIT; ack_in without req_in ignored.
REQ-021 EMIT: req_out=1, data_out/stream_id stable until transfer; ack_out low holds state indefinitely.
REQ-022 EMIT transfer with s==NR_STREAMS-1: s <= 0, next DECIDE.
REQ-023 EMIT transfer otherwise: s <= s+1; shift frame -> FETCH; no-shift frame -> stay EMIT, data_out <= hist[s+1], req_out stays high (back-to-back outputs).
REQ-024 SHALL produce exactly NR_STREAMS outputs per frame, streams in order 0..NR_STREAMS-1.
REQ-025 Throughput: shift frame 2*NR_STREAMS+1 cycles minimum, no-shift frame NR_STREAMS+1 cycles minimum.
REQ-026 Over L consecutive frames SHALL perform exactly M shift frames; acc SHALL stay in 0..L-1.
REQ-027 With M==L every frame SHALL be a shift frame.
REQ-028 No arithmetic on samples; data passed bit-exact; acc width clog2(2*L).

Reset
REQ-029 On rst: req_in=0, req_out=0, data_out=0, stream_id=0, shifted=0, acc=0, all hist=0, state DECIDE, next cycle.
REQ-030 rst mid-FETCH or mid-EMIT SHALL abort the frame; pending handshake dropped, no partial hist update.
REQ-031 rst SHALL dominate simultaneous ack_in/ack_out.

Structure
REQ-032 Package resampler_pkg SHALL hold default DWIDTH/TAPS/NR_STREAMS/L/M and the state enumeration.
REQ-033 Phase accumulator SHALL be sub-module resample_phase_ctrl (inputs clk, rst, step; outputs shift, acc).
REQ-034 History storage SHALL be a register array; no RAM macro required.

Verification
REQ-035 Reset, ack_in=1, ack_out=1 constant, L=M=4, NR_STREAMS=2, TAPS=4, inputs 1,2,3,... -> stream0 windows {1,0,0,0},{3,1,0,0}; stream1 {2,0,0,0},{4,2,0,0}.
REQ-036 L=160, M=147, 160 frames -> exactly 147 frames with shifted=1, acc==0 after frame 160.
REQ-037 No-shift frame, ack_out=1 constant -> req_out high NR_STREAMS consecutive cycles, data_out equals previous frame windows.
REQ-038 ack_out held low 10 cycles in EMIT -> data_out, stream_id stable, req_in=0 throughout.
REQ-039 ack_in random 30% duty -> no lost/duplicated sample; req_in and req_out never both high.
REQ-040 rst asserted during FETCH of stream 5 -> next outputs all-zero windows starting stream_id=0, acc=0.
